// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Runs mult/multu/div/divu as a fixed ITER-step shift-add or restoring-divide loop on magnitudes.
module mdu_iterative #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             signA_q, signA_d;
  logic             signB_q, signB_d;
  logic [WIDTH-1:0] aMag_q, aMag_d;
  logic [WIDTH-1:0] bMag_q, bMag_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]     mulSum, divShift, divTrial;
  logic [WIDTH-1:0]   stepAcc, stepLow;
  logic [2*WIDTH-1:0] product, mulRes;
  logic [WIDTH-1:0]   resHi, resLo;
  logic               negQ, isSignedIn;

  // One iteration: acc holds the running upper product / partial remainder,
  // low holds the multiplier being shifted out / dividend bits becoming the quotient.
  always_comb begin
    mulSum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, bMag_q} : '0);
    divShift = {acc_q, low_q[WIDTH-1]};
    divTrial = divShift - {1'b0, bMag_q};
    if (op_q[1]) begin
      if (!divTrial[WIDTH]) begin
        stepAcc = divTrial[WIDTH-1:0];
        stepLow = {low_q[WIDTH-2:0], 1'b1};
      end else begin
        stepAcc = divShift[WIDTH-1:0];
        stepLow = {low_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      stepAcc = mulSum[WIDTH:1];
      stepLow = {mulSum[0], low_q[WIDTH-1:1]};
    end
  end

  // Sign correction applied to the final iteration's output so HI/LO are valid in FIN.
  always_comb begin
    negQ    = ~op_q[0] & (signA_q ^ signB_q);
    product = {stepAcc, stepLow};
    mulRes  = negQ ? -product : product;
    resHi   = mulRes[2*WIDTH-1:WIDTH];
    resLo   = mulRes[WIDTH-1:0];
    if (op_q[1]) begin
      if (bMag_q == '0) begin
        resLo = '1;
        resHi = signA_q ? -aMag_q : aMag_q;
      end else begin
        resLo = negQ ? -stepLow : stepLow;
        resHi = signA_q ? -stepAcc : stepAcc;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    signA_d    = signA_q;
    signB_d    = signB_q;
    aMag_d     = aMag_q;
    bMag_d     = bMag_q;
    acc_d      = acc_q;
    low_d      = low_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    isSignedIn = ~op[0];
    unique case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          op_d    = op;
          signA_d = isSignedIn & a[WIDTH-1];
          signB_d = isSignedIn & b[WIDTH-1];
          aMag_d  = (isSignedIn & a[WIDTH-1]) ? -a : a;
          bMag_d  = (isSignedIn & b[WIDTH-1]) ? -b : b;
          acc_d   = '0;
          low_d   = (isSignedIn & a[WIDTH-1]) ? -a : a;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = stepAcc;
        low_d = stepLow;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) begin
          cnt_d   = '0;
          hi_d    = resHi;
          lo_d    = resLo;
          state_d = FIN;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      signA_q <= 1'b0;
      signB_q <= 1'b0;
      aMag_q  <= '0;
      bMag_q  <= '0;
      acc_q   <= '0;
      low_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      signA_q <= signA_d;
      signB_q <= signB_d;
      aMag_q  <= aMag_d;
      bMag_q  <= bMag_d;
      acc_q   <= acc_d;
      low_q   <= low_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == FIN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
